// File: rtl/laser_point_feeder.sv
// Feeds a host-loaded point set to the LASER core and captures its centre results.
// Define COVER_SCORE_EN to add the post-run covered-point scoring pass; otherwise SCORE is 0.
module laser_point_feeder #(
  parameter int NUM_PTS = 40,
  parameter int COORD_W = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [5:0]         WR_ADDR,
  input  logic [COORD_W-1:0] WR_X,
  input  logic [COORD_W-1:0] WR_Y,
  input  logic               START,
  output logic               BUSY,
  output logic               LASER_RST,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic [COORD_W-1:0] RES_C1X,
  output logic [COORD_W-1:0] RES_C1Y,
  output logic [COORD_W-1:0] RES_C2X,
  output logic [COORD_W-1:0] RES_C2Y,
  output logic               RES_VALID,
  output logic               TIMEOUT_ERR,
  output logic [5:0]         SCORE
);

  localparam int               CNT_W     = 10;
  localparam logic [5:0]       NUM_PTS_A = 6'(NUM_PTS);
  localparam logic [5:0]       LAST_IDX  = 6'(NUM_PTS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_STREAM,
    S_WAIT_DONE,
    S_REPORT
`ifdef COVER_SCORE_EN
    , S_SCORE
`endif
  } state_t;

  state_t             state_reg, state_next;
  logic [5:0]         idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [COORD_W-1:0] x_reg, x_next, y_reg, y_next;
  logic               laser_rst_reg, laser_rst_next;
  logic [COORD_W-1:0] res_c1x_reg, res_c1x_next, res_c1y_reg, res_c1y_next;
  logic [COORD_W-1:0] res_c2x_reg, res_c2x_next, res_c2y_reg, res_c2y_next;
  logic               timeout_err_reg, timeout_err_next;

  logic [NUM_PTS-1:0][COORD_W-1:0] mem_x, mem_y;
  logic                            mem_we;

  // The point set is frozen for the whole frame: writes land only in IDLE.
  assign mem_we = (state_reg == S_IDLE) && WR_EN && (WR_ADDR < NUM_PTS_A);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PTS; gi++) begin : g_pt
      logic [COORD_W-1:0] pt_x_reg, pt_y_reg;
      always_ff @(posedge CLK) begin
        if (RST) begin
          pt_x_reg <= '0;
          pt_y_reg <= '0;
        end else if (mem_we && (WR_ADDR == 6'(gi))) begin
          pt_x_reg <= WR_X;
          pt_y_reg <= WR_Y;
        end
      end
      assign mem_x[gi] = pt_x_reg;
      assign mem_y[gi] = pt_y_reg;
    end
  endgenerate

`ifdef COVER_SCORE_EN
  localparam int                     SQ_W      = 2 * COORD_W + 3;
  localparam logic signed [SQ_W-1:0] RADIUS    = SQ_W'(4);
  localparam logic signed [SQ_W-1:0] RADIUS_SQ = SQ_W'(16);

  logic [5:0] acc_reg, acc_next, score_reg, score_next;
  logic       hit;

  function automatic logic in_circle(input logic [COORD_W-1:0] px, py, cx, cy);
    logic signed [SQ_W-1:0] dx, dy;
    dx = SQ_W'(px) - SQ_W'(cx);
    dy = SQ_W'(py) - SQ_W'(cy);
    return (dx >= -RADIUS) && (dx <= RADIUS) && (dy >= -RADIUS) && (dy <= RADIUS) &&
           ((dx * dx + dy * dy) <= RADIUS_SQ);
  endfunction

  assign hit = in_circle(mem_x[idx_reg], mem_y[idx_reg], res_c1x_reg, res_c1y_reg) ||
               in_circle(mem_x[idx_reg], mem_y[idx_reg], res_c2x_reg, res_c2y_reg);
  assign SCORE = score_reg;
`else
  assign SCORE = '0;
`endif

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    cnt_next         = cnt_reg;
    x_next           = '0;
    y_next           = '0;
    laser_rst_next   = 1'b0;
    res_c1x_next     = res_c1x_reg;
    res_c1y_next     = res_c1y_reg;
    res_c2x_next     = res_c2x_reg;
    res_c2y_next     = res_c2y_reg;
    timeout_err_next = timeout_err_reg;
`ifdef COVER_SCORE_EN
    acc_next         = acc_reg;
    score_next       = score_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          state_next       = S_PULSE;
          laser_rst_next   = 1'b1;
          timeout_err_next = 1'b0;
        end
      end
      S_PULSE: begin
        // X/Y are registered, so the first point is fetched one cycle ahead.
        state_next = S_STREAM;
        idx_next   = '0;
        x_next     = mem_x[0];
        y_next     = mem_y[0];
      end
      S_STREAM: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_WAIT_DONE;
          cnt_next   = '0;
        end else begin
          idx_next = idx_reg + 6'd1;
          x_next   = mem_x[idx_next];
          y_next   = mem_y[idx_next];
        end
      end
      S_WAIT_DONE: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (DONE) begin
          res_c1x_next = C1X;
          res_c1y_next = C1Y;
          res_c2x_next = C2X;
          res_c2y_next = C2Y;
`ifdef COVER_SCORE_EN
          state_next   = S_SCORE;
          idx_next     = '0;
          acc_next     = '0;
`else
          state_next   = S_REPORT;
`endif
        end else if (cnt_next == TIMEOUT_C) begin
          state_next       = S_REPORT;
          timeout_err_next = 1'b1;
          res_c1x_next     = '0;
          res_c1y_next     = '0;
          res_c2x_next     = '0;
          res_c2y_next     = '0;
`ifdef COVER_SCORE_EN
          score_next       = '0;
`endif
        end
      end
`ifdef COVER_SCORE_EN
      S_SCORE: begin
        acc_next = acc_reg + 6'(hit);
        if (idx_reg == LAST_IDX) begin
          score_next = acc_next;
          state_next = S_REPORT;
        end else begin
          idx_next = idx_reg + 6'd1;
        end
      end
`endif
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      laser_rst_reg   <= 1'b1;
      res_c1x_reg     <= '0;
      res_c1y_reg     <= '0;
      res_c2x_reg     <= '0;
      res_c2y_reg     <= '0;
      timeout_err_reg <= 1'b0;
`ifdef COVER_SCORE_EN
      acc_reg         <= '0;
      score_reg       <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      laser_rst_reg   <= laser_rst_next;
      res_c1x_reg     <= res_c1x_next;
      res_c1y_reg     <= res_c1y_next;
      res_c2x_reg     <= res_c2x_next;
      res_c2y_reg     <= res_c2y_next;
      timeout_err_reg <= timeout_err_next;
`ifdef COVER_SCORE_EN
      acc_reg         <= acc_next;
      score_reg       <= score_next;
`endif
    end
  end

  assign BUSY        = (state_reg != S_IDLE);
  assign RES_VALID   = (state_reg == S_REPORT);
  assign LASER_RST   = laser_rst_reg;
  assign X           = x_reg;
  assign Y           = y_reg;
  assign RES_C1X     = res_c1x_reg;
  assign RES_C1Y     = res_c1y_reg;
  assign RES_C2X     = res_c2x_reg;
  assign RES_C2Y     = res_c2y_reg;
  assign TIMEOUT_ERR = timeout_err_reg;

endmodule
